// File: rtl/sim_jtag_if.sv
`default_nettype none
// ============================================================================
//  Module      : sim_jtag_if
//  Description : Pin bundle between the bench-side JTAG host (master) and
//                the debug TAP / environment side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sim_jtag_if;
    logic        enable;
    logic        init_done;
    logic        jtag_TCK;
    logic        jtag_TMS;
    logic        jtag_TDI;
    logic        jtag_TRSTn;
    logic        srstn;
    logic        jtag_TDO_data;
    logic        jtag_TDO_driven;
    logic [31:0] exit;

    // Host side: drives the JTAG pins and the exit code
    modport master (
        input  enable, init_done, jtag_TDO_data, jtag_TDO_driven,
        output jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, srstn, exit
    );

    // Environment / TAP side
    modport slave (
        output enable, init_done, jtag_TDO_data, jtag_TDO_driven,
        input  jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, srstn, exit
    );
endinterface
`default_nettype wire

// File: rtl/sim_jtag.sv
`default_nettype none
// ============================================================================
//  Module      : sim_jtag
//  Description : Bench-side JTAG bit-bang host. Pins change on ticks derived
//                from clk. Runs a TAP reset followed by an IDCODE read.
//  Revision    : 1.0 - initial release
// ============================================================================
module sim_jtag #(
    parameter int TICK_DELAY = 50
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sim_jtag_if.master  bus
);

    localparam int c_CNT_W = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(TICK_DELAY);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tck;
    logic               r_tms;
    logic               r_tdi;
    logic               r_trstn;
    logic [31:0]        r_exit;
    logic               w_run;
    logic               w_tick;
    logic               w_tdo;

    // Ticks only advance while the host is enabled, ready, and not finished
    assign w_run  = bus.enable && bus.init_done && (r_exit == 32'd0);
    assign w_tick = w_run && (r_cnt == '0);
    // An undriven TDO line reads as the pull-up value
    assign w_tdo  = bus.jtag_TDO_driven ? bus.jtag_TDO_data : 1'b1;

    // Tick divider: count down while running, reload after each tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= c_RELOAD;
        end else if (w_run) begin
            if (r_cnt == '0) begin
                r_cnt <= c_RELOAD;
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end
    end

    typedef enum logic [2:0] {
        S_TRST = 3'd0,   // two ticks holding TRSTn low
        S_LOW  = 3'd1,   // TCK low phase: set TMS/TDI for cycle r_n
        S_HIGH = 3'd2,   // TCK high phase: sample TDO
        S_FIN  = 3'd3,   // final TCK low and exit code
        S_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_n;
    logic [5:0]  w_n_nxt;
    logic [31:0] r_idcode;
    logic [31:0] w_idcode_nxt;
    logic        w_tck_nxt;
    logic        w_tms_nxt;
    logic        w_tdi_nxt;
    logic        w_trstn_nxt;
    logic [31:0] w_exit_nxt;

    // TMS walk: reset TAP, go to Run-Test/Idle, into Shift-DR, shift 32
    // bits, then Exit1-DR -> Update-DR -> Run-Test/Idle
    function automatic logic f_tms(input logic [5:0] n);
        return (n <= 6'd5) || (n == 6'd7) || (n == 6'd41) || (n == 6'd42);
    endfunction

    // Sequencer state and registered pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_TRST;
            r_n      <= 6'd0;
            r_idcode <= 32'd0;
            r_tck    <= 1'b0;
            r_tms    <= 1'b0;
            r_tdi    <= 1'b0;
            r_trstn  <= 1'b1;
            r_exit   <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_n      <= w_n_nxt;
            r_idcode <= w_idcode_nxt;
            r_tck    <= w_tck_nxt;
            r_tms    <= w_tms_nxt;
            r_tdi    <= w_tdi_nxt;
            r_trstn  <= w_trstn_nxt;
            r_exit   <= w_exit_nxt;
        end
    end

    // One sequence step per tick; everything holds between ticks
    always_comb begin
        w_state_nxt  = r_state;
        w_n_nxt      = r_n;
        w_idcode_nxt = r_idcode;
        w_tck_nxt    = r_tck;
        w_tms_nxt    = r_tms;
        w_tdi_nxt    = r_tdi;
        w_trstn_nxt  = r_trstn;
        w_exit_nxt   = r_exit;
        if (w_tick) begin
            case (r_state)
                S_TRST: begin
                    w_trstn_nxt = 1'b0;
                    w_tck_nxt   = 1'b0;
                    if (r_n == 6'd1) begin
                        w_n_nxt     = 6'd1;
                        w_state_nxt = S_LOW;
                    end else begin
                        w_n_nxt = r_n + 6'd1;
                    end
                end
                S_LOW: begin
                    w_trstn_nxt = 1'b1;
                    w_tck_nxt   = 1'b0;
                    w_tms_nxt   = f_tms(r_n);
                    w_tdi_nxt   = 1'b0;
                    w_state_nxt = S_HIGH;
                end
                S_HIGH: begin
                    w_tck_nxt = 1'b1;
                    // Shift-DR sampling window: cycle 10 is IDCODE bit 0
                    if ((r_n >= 6'd10) && (r_n <= 6'd41)) begin
                        w_idcode_nxt = {w_tdo, r_idcode[31:1]};
                    end
                    if (r_n == 6'd43) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_n_nxt     = r_n + 6'd1;
                        w_state_nxt = S_LOW;
                    end
                end
                S_FIN: begin
                    w_tck_nxt   = 1'b0;
                    // A valid IDCODE always has bit 0 set
                    w_exit_nxt  = r_idcode[0] ? 32'd1 : 32'd3;
                    w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_TRST;
                end
            endcase
        end
    end

    assign bus.jtag_TCK   = r_tck;
    assign bus.jtag_TMS   = r_tms;
    assign bus.jtag_TDI   = r_tdi;
    assign bus.jtag_TRSTn = r_trstn;
    assign bus.srstn      = 1'b1;
    assign bus.exit       = r_exit;

endmodule
`default_nettype wire

// File: tb/tb_sim_jtag.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sim_jtag
//  Description : Self-checking bench for sim_jtag with a behavioural TAP
//                that returns a programmable IDCODE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_jtag;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sim_jtag_if bus0();
    sim_jtag_if bus3();

    sim_jtag #(.TICK_DELAY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sim_jtag #(.TICK_DELAY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural TAP (IEEE 1149.1 state graph) -----------
    localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                   PAUDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                   SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

    int          tap_st = TLR;
    logic [31:0] tap_sh = 32'd0;
    logic [31:0] tap_id = 32'd0;
    logic        tap_drv = 1'b1;

    function automatic int tap_next(input int s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDR  : PAUDR;
            PAUDR: return tms ? EX2DR : PAUDR;
            EX2DR: return tms ? UPDR  : SHDR;
            UPDR:  return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPIR  : PAUIR;
            PAUIR: return tms ? EX2IR : PAUIR;
            EX2IR: return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge bus0.jtag_TCK or negedge bus0.jtag_TRSTn) begin
        if (!bus0.jtag_TRSTn) begin
            tap_st <= TLR;
        end else begin
            if (tap_st == CAPDR)     tap_sh <= tap_id;
            else if (tap_st == SHDR) tap_sh <= {1'b0, tap_sh[31:1]};
            tap_st <= tap_next(tap_st, bus0.jtag_TMS);
        end
    end

    assign bus0.jtag_TDO_data   = tap_drv ? tap_sh[0] : 1'b0;
    assign bus0.jtag_TDO_driven = tap_drv;
    assign bus3.jtag_TDO_data   = 1'b1;
    assign bus3.jtag_TDO_driven = 1'b1;

    // TMS seen at each TCK rise; newest in bit 0
    int          tck_total = 0;
    logic [63:0] tms_hist  = 64'd0;
    always @(posedge bus0.jtag_TCK) begin
        tck_total = tck_total + 1;
        tms_hist  = {tms_hist[62:0], bus0.jtag_TMS};
    end

    // ---------------- vector table ----------------------------------------
    typedef struct {
        logic [31:0] idcode;
        logic        driven;
        int          pause_at;   // 0 = no pause
        logic [31:0] exp_cap;
        logic [31:0] exp_exit;
        int          exp_clocks; // enable -> exit nonzero, TICK_DELAY=0
    } vec_t;

    vec_t        vecs[5];
    logic [42:0] exp_tms;

    task automatic run_vec(input vec_t v, input int idx);
        int   clocks;
        int   tck0;
        logic frozen;
        logic [3:0] snap;
        rst = 1'b1;
        bus0.enable = 1'b0;
        bus0.init_done = 1'b0;
        tap_id  = v.idcode;
        tap_drv = v.driven;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tck0 = tck_total;
        bus0.enable = 1'b1;
        bus0.init_done = 1'b1;
        clocks = 0;
        while (bus0.exit == 32'd0 && clocks < 400) begin
            @(negedge clk);
            clocks++;
            if (clocks == v.pause_at) begin
                snap = {bus0.jtag_TCK, bus0.jtag_TMS, bus0.jtag_TDI, bus0.jtag_TRSTn};
                bus0.init_done = 1'b0;
                frozen = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    clocks++;
                    if ({bus0.jtag_TCK, bus0.jtag_TMS, bus0.jtag_TDI, bus0.jtag_TRSTn} != snap)
                        frozen = 1'b0;
                end
                check($sformatf("v%0d_pause_frozen", idx), 64'(frozen), 64'd1);
                bus0.init_done = 1'b1;
            end
        end
        check($sformatf("v%0d_clocks", idx), 64'(clocks), 64'(v.exp_clocks));
        check($sformatf("v%0d_exit", idx), 64'(bus0.exit), 64'(v.exp_exit));
        check($sformatf("v%0d_idcode", idx), 64'(u_dut0.r_idcode), 64'(v.exp_cap));
        check($sformatf("v%0d_tck_rises", idx), 64'(tck_total - tck0), 64'd43);
        check($sformatf("v%0d_tms_pattern", idx), 64'(tms_hist[42:0]), 64'(exp_tms));
        check($sformatf("v%0d_tck_final", idx), 64'(bus0.jtag_TCK), 64'd0);
    endtask

    initial begin
        logic [3:0] prev3;
        logic [3:0] cur3;
        int         clocks;

        vecs[0] = '{32'h249511C3, 1'b1, 0,  32'h249511C3, 32'd1, 89};
        vecs[1] = '{32'h00000000, 1'b1, 0,  32'h00000000, 32'd3, 89};
        vecs[2] = '{32'h249511C3, 1'b0, 0,  32'hFFFFFFFF, 32'd1, 89};
        vecs[3] = '{32'h12345678, 1'b1, 0,  32'h12345678, 32'd3, 89};
        vecs[4] = '{32'h249511C3, 1'b1, 30, 32'h249511C3, 32'd1, 109};
        for (int n = 1; n <= 43; n++)
            exp_tms[43 - n] = (n <= 5) || (n == 7) || (n == 41) || (n == 42);

        bus0.enable = 1'b0; bus0.init_done = 1'b0;
        bus3.enable = 1'b0; bus3.init_done = 1'b0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_tck",   64'(bus0.jtag_TCK),   64'd0);
        check("rst_tms",   64'(bus0.jtag_TMS),   64'd0);
        check("rst_tdi",   64'(bus0.jtag_TDI),   64'd0);
        check("rst_trstn", 64'(bus0.jtag_TRSTn), 64'd1);
        check("rst_srstn", 64'(bus0.srstn),      64'd1);
        check("rst_exit",  64'(bus0.exit),       64'd0);

        // ---- tick rate, TICK_DELAY=3 ----
        rst = 1'b0;
        @(negedge clk);
        bus3.enable = 1'b1;
        bus3.init_done = 1'b1;
        prev3 = {bus3.jtag_TCK, bus3.jtag_TMS, bus3.jtag_TDI, bus3.jtag_TRSTn};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            cur3 = {bus3.jtag_TCK, bus3.jtag_TMS, bus3.jtag_TDI, bus3.jtag_TRSTn};
            // tick 1 (clock 8) repeats tick 0's pins, so nothing visibly changes
            check($sformatf("rate_change_c%0d", c), 64'(cur3 != prev3),
                  64'((c % 4 == 0) && (c != 8)));
            if (c == 3)  check("rate_trstn_c3",  64'(bus3.jtag_TRSTn), 64'd1);
            if (c == 4)  check("rate_trstn_c4",  64'(bus3.jtag_TRSTn), 64'd0);
            if (c == 11) check("rate_trstn_c11", 64'(bus3.jtag_TRSTn), 64'd0);
            if (c == 12) check("rate_trstn_c12", 64'(bus3.jtag_TRSTn), 64'd1);
            prev3 = cur3;
        end
        bus3.enable = 1'b0;

        // ---- table-driven IDCODE runs ----
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], i);
            if (i == 0) begin
                repeat (10) @(negedge clk);
                check("sticky_exit", 64'(bus0.exit),     64'd1);
                check("sticky_tck",  64'(bus0.jtag_TCK), 64'd0);
                check("sticky_srstn", 64'(bus0.srstn),   64'd1);
            end
        end

        // ---- reset in mid-sequence, then full restart ----
        rst = 1'b1;
        bus0.enable = 1'b0;
        bus0.init_done = 1'b0;
        tap_id = 32'h249511C3;
        tap_drv = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus0.enable = 1'b1;
        bus0.init_done = 1'b1;
        repeat (50) @(negedge clk);
        check("mid_tck_before", 64'(bus0.jtag_TCK), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_tck",   64'(bus0.jtag_TCK),   64'd0);
        check("mid_rst_trstn", 64'(bus0.jtag_TRSTn), 64'd1);
        check("mid_rst_tms",   64'(bus0.jtag_TMS),   64'd0);
        check("mid_rst_exit",  64'(bus0.exit),       64'd0);
        @(negedge clk);
        rst = 1'b0;
        clocks = 0;
        while (bus0.exit == 32'd0 && clocks < 400) begin
            @(negedge clk);
            clocks++;
        end
        check("mid_restart_clocks", 64'(clocks), 64'd89);
        check("mid_restart_exit",   64'(bus0.exit), 64'd1);
        check("mid_restart_idcode", 64'(u_dut0.r_idcode), 64'h249511C3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
